bin2bcd_arb: RTL



---
 rtl/bin2bcd_arb_if.sv | 28 ++
 rtl/bin2bcd_arb.sv | 132 +++++++++++++
 2 files changed

// File: rtl/bin2bcd_arb_if.sv
// Request/response and converter-side bus of the shared bin2bcd arbiter.
// The slave modport is the arbiter's view; master is the requester/converter view.
interface bin2bcd_arb_if #(
  parameter int NREQ  = 4,
  parameter int BIN_W = 11,
  parameter int BCD_W = 17
);
  logic [NREQ-1:0]       req_vld;
  logic [NREQ*BIN_W-1:0] req_bin;
  logic [NREQ-1:0]       req_rdy;
  logic [NREQ-1:0]       rsp_vld;
  logic [BCD_W-1:0]      rsp_bcd;
  logic                  rsp_err;
  logic [BIN_W-1:0]      cvt_bin;
  logic                  cvt_bin_vld;
  logic [BCD_W-1:0]      cvt_bcd;
  logic                  cvt_bcd_vld;

  modport slave (
    input  req_vld, req_bin, cvt_bcd, cvt_bcd_vld,
    output req_rdy, rsp_vld, rsp_bcd, rsp_err, cvt_bin, cvt_bin_vld
  );

  modport master (
    output req_vld, req_bin, cvt_bcd, cvt_bcd_vld,
    input  req_rdy, rsp_vld, rsp_bcd, rsp_err, cvt_bin, cvt_bin_vld
  );
endinterface

// File: rtl/bin2bcd_arb.sv
// Round-robin sequencer sharing one bin2bcd converter among NREQ requesters,
// with a per-conversion timeout and requester-tagged single-cycle responses.
module bin2bcd_arb #(
  parameter int NREQ  = 4,
  parameter int BIN_W = 11,
  parameter int BCD_W = 17,
  parameter int TMO   = 64
) (
  input  logic         clk,
  input  logic         rst,
  bin2bcd_arb_if.slave bus,
  output logic         busy
);
  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TMO);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [NREQ-1:0]   req_rdy_q, req_rdy_d;
  logic [NREQ-1:0]   rsp_vld_q, rsp_vld_d;
  logic [BCD_W-1:0]  rsp_bcd_q, rsp_bcd_d;
  logic              rsp_err_q, rsp_err_d;
  logic [BIN_W-1:0]  cvt_bin_q, cvt_bin_d;
  logic              cvt_bin_vld_q, cvt_bin_vld_d;
  logic              busy_q, busy_d;
  logic [PW-1:0]     grant_s;
  logic [PW-1:0]     cand_s;

  // Round-robin pick: scan downward so the nearest requester after ptr wins.
  always_comb begin
    grant_s = ptr_q;
    cand_s  = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand_s  = PW'((int'(ptr_q) + i) % NREQ);
      grant_s = bus.req_vld[cand_s] ? cand_s : grant_s;
    end
  end

  // Next-state and registered-output computation for the IDLE/WAIT sequencer.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gidx_d        = gidx_q;
    timer_d       = timer_q;
    req_rdy_d     = '0;
    rsp_vld_d     = '0;
    rsp_bcd_d     = rsp_bcd_q;
    rsp_err_d     = rsp_err_q;
    cvt_bin_d     = cvt_bin_q;
    cvt_bin_vld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_vld != '0) begin
          cvt_bin_d          = bus.req_bin[int'(grant_s)*BIN_W +: BIN_W];
          cvt_bin_vld_d      = 1'b1;
          req_rdy_d[grant_s] = 1'b1;
          gidx_d             = grant_s;
          ptr_d              = grant_s;
          timer_d            = '0;
          state_d            = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        // A result arriving on the expiry cycle still counts as success.
        if (bus.cvt_bcd_vld) begin
          rsp_bcd_d         = bus.cvt_bcd;
          rsp_err_d         = 1'b0;
          rsp_vld_d[gidx_q] = 1'b1;
          state_d           = IDLE;
        end else if (timer_q == TW'(TMO - 1)) begin
          rsp_bcd_d         = '0;
          rsp_err_d         = 1'b1;
          rsp_vld_d[gidx_q] = 1'b1;
          state_d           = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= PW'(NREQ - 1);
      gidx_q        <= '0;
      timer_q       <= '0;
      req_rdy_q     <= '0;
      rsp_vld_q     <= '0;
      rsp_bcd_q     <= '0;
      rsp_err_q     <= 1'b0;
      cvt_bin_q     <= '0;
      cvt_bin_vld_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gidx_q        <= gidx_d;
      timer_q       <= timer_d;
      req_rdy_q     <= req_rdy_d;
      rsp_vld_q     <= rsp_vld_d;
      rsp_bcd_q     <= rsp_bcd_d;
      rsp_err_q     <= rsp_err_d;
      cvt_bin_q     <= cvt_bin_d;
      cvt_bin_vld_q <= cvt_bin_vld_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.req_rdy     = req_rdy_q;
  assign bus.rsp_vld     = rsp_vld_q;
  assign bus.rsp_bcd     = rsp_bcd_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.cvt_bin     = cvt_bin_q;
  assign bus.cvt_bin_vld = cvt_bin_vld_q;
  assign busy            = busy_q;
endmodule
